// File: rtl/ex_stage_if.sv
// Decode <-> execute bundle: decoded op in, EX forwarding / EX-MEM latch / HI-LO state out.
interface ex_stage_if;
    logic        stall_i;
    logic        flush_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;

    logic        ex_wreg_o;
    logic [4:0]  ex_wd_o;
    logic [31:0] ex_wdata_o;
    logic        mem_wreg_o;
    logic [4:0]  mem_wd_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output stall_i, flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        input  ex_wreg_o, ex_wd_o, ex_wdata_o, mem_wreg_o, mem_wd_o, mem_wdata_o, hi_o, lo_o
    );

    modport slave (
        input  stall_i, flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        output ex_wreg_o, ex_wd_o, ex_wdata_o, mem_wreg_o, mem_wd_o, mem_wdata_o, hi_o, lo_o
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ID/EX latch, logic/shift/move ALU, EX/MEM latch and HI/LO registers.
// Latency: decode at N -> ex_* at N+1, mem_* at N+2, HI/LO visible at N+3.
// Backpressure: stall_i holds ID/EX and injects a bubble into EX/MEM; flush_i loads a NOP.
module ex_stage (
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);
    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_MOVZ_OP = 8'b0000_1010;
    localparam logic [7:0] EXE_MOVN_OP = 8'b0000_1011;
    localparam logic [7:0] EXE_MFHI_OP = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP = 8'b0001_0011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1, reg2;
    logic [4:0]  wd;
    logic        wreg;

    logic        mem_wreg;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic        mem_hilo_we;
    logic        mem_hilo_sel;   // 0 = HI, 1 = LO
    logic [31:0] mem_hilo_data;
    logic [31:0] hi, lo;

    logic [31:0] result;
    logic [31:0] hi_eff, lo_eff;
    logic [4:0]  shamt;
    logic        hilo_we;
    logic        hilo_sel;

    always_comb begin
        shamt    = reg1[4:0];
        // A HI/LO write still sitting in EX/MEM is newer than the architectural register.
        hi_eff   = (mem_hilo_we && !mem_hilo_sel) ? mem_hilo_data : hi;
        lo_eff   = (mem_hilo_we &&  mem_hilo_sel) ? mem_hilo_data : lo;
        hilo_we  = (aluop == EXE_MTHI_OP) || (aluop == EXE_MTLO_OP);
        hilo_sel = (aluop == EXE_MTLO_OP);
        result   = 32'd0;
        case (alusel)
            EXE_RES_LOGIC: begin
                case (aluop)
                    EXE_AND_OP: result = reg1 & reg2;
                    EXE_OR_OP:  result = reg1 | reg2;
                    EXE_XOR_OP: result = reg1 ^ reg2;
                    EXE_NOR_OP: result = ~(reg1 | reg2);
                    default:    result = 32'd0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (aluop)
                    EXE_SLL_OP: result = reg2 << shamt;
                    EXE_SRL_OP: result = reg2 >> shamt;
                    EXE_SRA_OP: result = 32'($signed(reg2) >>> shamt);
                    default:    result = 32'd0;
                endcase
            end
            EXE_RES_MOVE: begin
                case (aluop)
                    EXE_MOVZ_OP, EXE_MOVN_OP: result = reg1;
                    EXE_MFHI_OP:              result = hi_eff;
                    EXE_MFLO_OP:              result = lo_eff;
                    default:                  result = 32'd0;
                endcase
            end
            default: result = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aluop         <= EXE_NOP_OP;
            alusel        <= EXE_RES_NOP;
            reg1          <= 32'd0;
            reg2          <= 32'd0;
            wd            <= 5'd0;
            wreg          <= 1'b0;
            mem_wreg      <= 1'b0;
            mem_wd        <= 5'd0;
            mem_wdata     <= 32'd0;
            mem_hilo_we   <= 1'b0;
            mem_hilo_sel  <= 1'b0;
            mem_hilo_data <= 32'd0;
            hi            <= 32'd0;
            lo            <= 32'd0;
        end else begin
            if (bus.flush_i) begin
                aluop  <= EXE_NOP_OP;
                alusel <= EXE_RES_NOP;
                reg1   <= 32'd0;
                reg2   <= 32'd0;
                wd     <= 5'd0;
                wreg   <= 1'b0;
            end else if (!bus.stall_i) begin
                aluop  <= bus.aluop_i;
                alusel <= bus.alusel_i;
                reg1   <= bus.reg1_i;
                reg2   <= bus.reg2_i;
                wd     <= bus.wd_i;
                wreg   <= bus.wreg_i;
            end

            // The held op re-executes next cycle, so only a bubble may leave now.
            if (bus.stall_i) begin
                mem_wreg      <= 1'b0;
                mem_wd        <= 5'd0;
                mem_wdata     <= 32'd0;
                mem_hilo_we   <= 1'b0;
                mem_hilo_sel  <= 1'b0;
                mem_hilo_data <= 32'd0;
            end else begin
                mem_wreg      <= wreg;
                mem_wd        <= wd;
                mem_wdata     <= result;
                mem_hilo_we   <= hilo_we;
                mem_hilo_sel  <= hilo_sel;
                mem_hilo_data <= reg1;
            end

            if (mem_hilo_we) begin
                if (mem_hilo_sel) lo <= mem_hilo_data;
                else              hi <= mem_hilo_data;
            end
        end
    end

    assign bus.ex_wreg_o   = wreg;
    assign bus.ex_wd_o     = wd;
    assign bus.ex_wdata_o  = result;
    assign bus.mem_wreg_o  = mem_wreg;
    assign bus.mem_wd_o    = mem_wd;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.hi_o        = hi;
    assign bus.lo_o        = lo;
endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage with hand-computed expectations.
module tb_ex_stage;
    localparam logic [7:0] NOP  = 8'b0000_0000;
    localparam logic [7:0] AND_ = 8'b0010_0100;
    localparam logic [7:0] OR_  = 8'b0010_0101;
    localparam logic [7:0] XOR_ = 8'b0010_0110;
    localparam logic [7:0] NOR_ = 8'b0010_0111;
    localparam logic [7:0] SLL  = 8'b0111_1100;
    localparam logic [7:0] SRL  = 8'b0000_0010;
    localparam logic [7:0] SRA  = 8'b0000_0011;
    localparam logic [7:0] MOVN = 8'b0000_1011;
    localparam logic [7:0] MFHI = 8'b0001_0000;
    localparam logic [7:0] MTHI = 8'b0001_0001;
    localparam logic [7:0] MFLO = 8'b0001_0010;
    localparam logic [7:0] MTLO = 8'b0001_0011;
    localparam logic [2:0] S_NOP = 3'b000;
    localparam logic [2:0] S_LOG = 3'b001;
    localparam logic [2:0] S_SHF = 3'b010;
    localparam logic [2:0] S_MOV = 3'b011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ex_stage_if bus ();
    ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [4:0] d, input logic we);
        bus.aluop_i  = op;
        bus.alusel_i = sel;
        bus.reg1_i   = r1;
        bus.reg2_i   = r2;
        bus.wd_i     = d;
        bus.wreg_i   = we;
    endtask

    task automatic idle();
        drive(NOP, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_exwreg"},  32'(bus.ex_wreg_o),   32'd0);
        check({tag, "_exwd"},    32'(bus.ex_wd_o),     32'd0);
        check({tag, "_exwdata"}, bus.ex_wdata_o,       32'd0);
        check({tag, "_memwreg"}, 32'(bus.mem_wreg_o),  32'd0);
        check({tag, "_memwd"},   32'(bus.mem_wd_o),    32'd0);
        check({tag, "_memwdata"}, bus.mem_wdata_o,     32'd0);
        check({tag, "_hi"},      bus.hi_o,             32'd0);
        check({tag, "_lo"},      bus.lo_o,             32'd0);
    endtask

    initial begin
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        // Garbage inputs during reset must not leak through.
        drive(OR_, S_LOG, 32'hFFFF_FFFF, 32'h1, 5'd9, 1'b1);
        bus.stall_i = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        bus.stall_i = 1'b0;
        idle();
        tick();

        // OR, then follow it into EX/MEM
        drive(OR_, S_LOG, 32'h0000_F0F0, 32'h0F0F_0000, 5'd3, 1'b1);
        tick();
        check("or_exwdata", bus.ex_wdata_o, 32'h0F0F_F0F0);
        check("or_exwd",    32'(bus.ex_wd_o), 32'd3);
        check("or_exwreg",  32'(bus.ex_wreg_o), 32'd1);
        drive(NOR_, S_LOG, 32'h0000_F0F0, 32'h0F0F_0000, 5'd4, 1'b1);
        tick();
        check("or_memwdata", bus.mem_wdata_o, 32'h0F0F_F0F0);
        check("or_memwd",    32'(bus.mem_wd_o), 32'd3);
        check("or_memwreg",  32'(bus.mem_wreg_o), 32'd1);
        check("nor_exwdata", bus.ex_wdata_o, 32'hF0F0_0F0F);
        drive(XOR_, S_LOG, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd4, 1'b1);
        tick();
        check("xor_exwdata", bus.ex_wdata_o, 32'hF0F0_F0F0);

        // Shifts, including upper shift-amount bits ignored
        drive(SRA, S_SHF, 32'd4, 32'h8000_0000, 5'd6, 1'b1);
        tick();
        check("sra_exwdata", bus.ex_wdata_o, 32'hF800_0000);
        drive(SRL, S_SHF, 32'd4, 32'h8000_0000, 5'd6, 1'b1);
        tick();
        check("srl_exwdata", bus.ex_wdata_o, 32'h0800_0000);
        drive(SRA, S_SHF, 32'h24, 32'h8000_0000, 5'd6, 1'b1);
        tick();
        check("sra24_exwdata", bus.ex_wdata_o, 32'hF800_0000);
        drive(SLL, S_SHF, 32'h24, 32'h0000_00F1, 5'd6, 1'b1);
        tick();
        check("sll24_exwdata", bus.ex_wdata_o, 32'h0000_0F10);

        // Move and unknown opcode
        drive(MOVN, S_MOV, 32'hCAFE_0000, 32'h1, 5'd8, 1'b1);
        tick();
        check("movn_exwdata", bus.ex_wdata_o, 32'hCAFE_0000);
        check("movn_exwreg",  32'(bus.ex_wreg_o), 32'd1);
        drive(8'hEE, S_LOG, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1);
        tick();
        check("unk_exwdata", bus.ex_wdata_o, 32'd0);
        check("unk_exwd",    32'(bus.ex_wd_o), 32'd7);
        check("unk_exwreg",  32'(bus.ex_wreg_o), 32'd1);

        // MTHI then MFHI: forwarded value before HI commits
        drive(MTHI, S_NOP, 32'h1234_5678, 32'd0, 5'd0, 1'b0);
        tick();
        check("mthi_exwreg", 32'(bus.ex_wreg_o), 32'd0);
        drive(MFHI, S_MOV, 32'd0, 32'd0, 5'd4, 1'b1);
        tick();
        check("mfhi_fwd",     bus.ex_wdata_o, 32'h1234_5678);
        check("mfhi_hi_stale", bus.hi_o,      32'd0);
        drive(MFLO, S_MOV, 32'd0, 32'd0, 5'd4, 1'b1);
        tick();
        check("hi_commit", bus.hi_o, 32'h1234_5678);
        check("mflo_exwdata", bus.ex_wdata_o, 32'd0);

        // Stall one cycle with AND latched
        drive(AND_, S_LOG, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd5, 1'b1);
        tick();
        check("and_exwdata0", bus.ex_wdata_o, 32'h0F00_0F00);
        bus.stall_i = 1'b1;
        drive(XOR_, S_LOG, 32'h1, 32'h2, 5'd9, 1'b1);
        tick();
        check("stall_exwdata1", bus.ex_wdata_o, 32'h0F00_0F00);
        check("stall_memwreg1", 32'(bus.mem_wreg_o), 32'd0);
        bus.stall_i = 1'b0;
        idle();
        tick();
        check("stall_exwdata2", bus.ex_wdata_o, 32'd0);
        check("stall_memwreg2", 32'(bus.mem_wreg_o), 32'd1);
        check("stall_memwdata2", bus.mem_wdata_o, 32'h0F00_0F00);
        check("stall_memwd2",   32'(bus.mem_wd_o), 32'd5);
        tick();
        check("stall_memwreg3", 32'(bus.mem_wreg_o), 32'd0);

        // Flush alone: EX gets NOP, the latched op still moves to EX/MEM
        drive(XOR_, S_LOG, 32'h0000_00FF, 32'h0000_0F0F, 5'd10, 1'b1);
        tick();
        bus.flush_i = 1'b1;
        tick();
        check("flush_exwreg",   32'(bus.ex_wreg_o), 32'd0);
        check("flush_memwdata", bus.mem_wdata_o, 32'h0000_0FF0);

        // Flush and stall together
        bus.flush_i = 1'b0;
        drive(OR_, S_LOG, 32'h1, 32'h2, 5'd11, 1'b1);
        tick();
        bus.flush_i = 1'b1;
        bus.stall_i = 1'b1;
        tick();
        check("fs_exwreg",  32'(bus.ex_wreg_o), 32'd0);
        check("fs_exwdata", bus.ex_wdata_o, 32'd0);
        check("fs_memwreg", 32'(bus.mem_wreg_o), 32'd0);
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b0;

        // Reset the cycle after MTLO: pending write discarded, HI cleared
        drive(MTLO, S_NOP, 32'hDEAD_BEEF, 32'd0, 5'd0, 1'b0);
        tick();
        rst = 1'b1;
        idle();
        tick();
        check_all_zero("rst_mtlo");
        rst = 1'b0;
        tick();
        check("rst_mtlo_lo_after", bus.lo_o, 32'd0);
        check("rst_mtlo_memwreg",  32'(bus.mem_wreg_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
